ram_rd_streamer: RTL and testbench

Read-side companion to the RAM fill sequencer. Once the writer has loaded the dual-port block RAM through port A, this block walks port B from address 0 and streams the stored words out over a valid/ready interface. A 2-entry skid buffer absorbs the one-cycle RAM read latency, so back-pressure never loses or duplicates a word.

---
 rtl/ram_if_pkg.sv | 6 +
 rtl/rd_skid_buf.sv | 38 +++
 rtl/ram_rd_streamer.sv | 78 +++++++
 tb/tb_ram_rd_streamer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ram_if_pkg.sv
// ram_if_pkg: RAM geometry defaults and FSM state encoding shared by the fill sequencer and the read streamer
package ram_if_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry FIFO that absorbs RAM read latency, with flow-through when empty
// Ports: push/din capture a word, pop consumes dout when valid, occupancy counts stored words.
module rd_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occupancy
);
  logic [W-1:0] mem_q [2];
  logic [1:0] occ_q;
  logic wr_q, rd_q, empty, store, take;
  assign empty = occ_q == 2'd0;
  // A word arriving into an empty buffer is presented directly; it is stored only if not taken at once.
  assign store = push && !(empty && pop);
  assign take = pop && !empty;
  assign valid = push || !empty;
  assign dout = !empty ? mem_q[rd_q] : push ? din : '0;
  assign occupancy = occ_q;
  always_ff @(posedge clk) if (store) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr_q ^ store;
      rd_q <= rd_q ^ take;
      occ_q <= occ_q + {1'b0, store} - {1'b0, take};
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && occ_q == 2'd2));
endmodule

// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer: walks RAM port B from address 0 and streams count words over valid/ready
// Ports: start/wr_done/count request a stream; enb/addrb/dob drive RAM port B;
// out_data/out_valid/out_ready form the stream; busy spans the stream, done pulses at the end.
module ram_rd_streamer
  import ram_if_pkg::*;
#(
  parameter int DATA_W = ram_if_pkg::DATA_W,
  parameter int ADDR_W = ram_if_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_done,
  input  logic [ADDR_W:0]   count,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dob,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t state_q, state_d;
  logic [ADDR_W:0] remaining_q, remaining_d, cnt_sat;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic enb_q, enb_d, inflight_q, busy_q, done_q, accept, pop;
  logic [1:0] occ, occ_nxt;
  assign cnt_sat = count > DEPTH ? DEPTH : count;
  assign accept = state_q == IDLE && start && wr_done;
  assign pop = out_valid && out_ready;
  // Buffer fill after this edge, before any new read lands.
  assign occ_nxt = occ + {1'b0, inflight_q} - {1'b0, pop};
  always_comb begin
    remaining_d = accept ? cnt_sat : remaining_q - (ADDR_W+1)'(enb_q);
    rd_addr_d = accept ? '0 : rd_addr_q + ADDR_W'(enb_q);
    state_d = state_q == IDLE  ? (accept ? (cnt_sat == '0 ? DONE : READ) : IDLE)
            : state_q == READ  ? (remaining_d == '0 ? DRAIN : READ)
            : state_q == DRAIN ? (occ_nxt == 2'd0 ? DONE : DRAIN)
            : IDLE;
    // Credit: the read issued now lands next cycle, so stored + landing words must stay below 2.
    enb_d = state_d == READ && occ_nxt + {1'b0, enb_q} < 2'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      remaining_q <= '0;
      rd_addr_q <= '0;
      enb_q <= 1'b0;
      inflight_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      rd_addr_q <= rd_addr_d;
      enb_q <= enb_d;
      inflight_q <= enb_q;
      busy_q <= state_d == READ || state_d == DRAIN;
      done_q <= state_d == DONE;
    end
  end
  assign enb = enb_q;
  assign addrb = rd_addr_q;
  assign busy = busy_q;
  assign done = done_q;
  rd_skid_buf #(.W(DATA_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(inflight_q),
    .din(dob),
    .pop(pop),
    .dout(out_data),
    .valid(out_valid),
    .occupancy(occ)
  );
endmodule

// File: tb/tb_ram_rd_streamer.sv
// tb_ram_rd_streamer: directed vector bench for ram_rd_streamer with a 1-cycle-latency RAM model
module tb_ram_rd_streamer;
  localparam int DW = 16;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic wr_done = 1'b0;
  logic out_ready = 1'b0;
  logic [AW:0] count = '0;
  logic enb, out_valid, busy, done;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob = '0;
  logic [DW-1:0] out_data;
  logic [DW-1:0] ram [4];
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic        wr_done;
    logic [2:0]  count;
    logic [15:0] ready;
    logic        restart;
    int          exp_n;
    int          exp_done;
  } vec_t;
  vec_t vecs [8];
  always #5 clk = ~clk;
  always @(posedge clk) if (enb) dob <= ram[addrb];
  ram_rd_streamer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .wr_done(wr_done),
    .count(count),
    .enb(enb),
    .addrb(addrb),
    .dob(dob),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask
  task automatic run_vec(input vec_t v);
    int issued, got, outstanding, done_t, n_done;
    logic stalled, pop;
    logic [DW-1:0] prev;
    issued = 0; got = 0; outstanding = 0; done_t = 0; n_done = 0;
    stalled = 1'b0; prev = '0;
    @(negedge clk);
    start = 1'b1; wr_done = v.wr_done; count = v.count; out_ready = v.ready[0];
    @(negedge clk);
    for (int t = 1; t < 16; t++) begin
      start = v.restart && t == 2;
      out_ready = v.ready[t];
      #1;
      if (t == 1) begin
        chk("busy_t1", busy, v.wr_done && v.count != 0);
        chk("enb_t1", enb, v.wr_done && v.count != 0);
      end
      if (t == 2) chk("valid_t2", out_valid, v.exp_n > 0);
      if (v.exp_n > 0 && t == v.exp_done - 1) chk("busy_before_done", busy, 1);
      if (t == v.exp_done) chk("busy_at_done", busy, 0);
      if (enb) begin
        chk("credit", outstanding < 2, 1);
        chk("addrb", addrb, issued % 4);
        issued++;
      end
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev);
      end
      pop = out_valid && out_ready;
      if (pop) begin
        if (got < v.exp_n) chk("word", out_data, ram[got]);
        else chk("extra_word", out_data, 32'hFFFF_FFFF);
        got++;
      end
      stalled = out_valid && !out_ready;
      prev = out_data;
      if (done) begin
        n_done++;
        if (done_t == 0) done_t = t;
      end
      outstanding = outstanding + (enb ? 1 : 0) - (pop ? 1 : 0);
      @(negedge clk);
    end
    start = 1'b0;
    chk("issues", issued, v.exp_n);
    chk("words", got, v.exp_n);
    chk("done_time", done_t, v.exp_done);
    chk("done_pulses", n_done, v.exp_done != 0);
  endtask
  initial begin
    ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333; ram[3] = 16'h4444;
    vecs[0] = '{1'b1, 3'd4, 16'hFFFF, 1'b0, 4, 6};
    vecs[1] = '{1'b1, 3'd4, 16'hFFA7, 1'b0, 4, 9};
    vecs[2] = '{1'b0, 3'd4, 16'hFFFF, 1'b0, 0, 0};
    vecs[3] = '{1'b1, 3'd0, 16'hFFFF, 1'b0, 0, 1};
    vecs[4] = '{1'b1, 3'd2, 16'hFFFF, 1'b1, 2, 4};
    vecs[5] = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 4, 6};
    vecs[6] = '{1'b1, 3'd1, 16'hFFFF, 1'b0, 1, 3};
    vecs[7] = '{1'b1, 3'd4, 16'hFFC0, 1'b0, 4, 10};
    repeat (2) @(negedge clk);
    #1 chk_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; wr_done = 1'b1; count = 3'd4; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1 chk("rst_start_busy", busy, 0);
    chk("rst_start_enb", enb, 0);
    @(negedge clk);
    #1 chk("rst_start_busy2", busy, 0);
    chk("rst_start_enb2", enb, 0);
    chk("rst_start_valid2", out_valid, 0);
    @(negedge clk);
    start = 1'b1; count = 3'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0; rst = 1'b1;
    #1 chk("mid_valid", out_valid, 1);
    chk("mid_data", out_data, 16'h3333);
    @(negedge clk);
    #1 chk_reset();
    rst = 1'b0; out_ready = 1'b1;
    run_vec(vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
